// File: rtl/mp3_cmd_ctrl.sv
// Playback command controller: decodes UART command bytes and end-of-song pulses into
// registered volume, song index, pause and play-mode state for the VS1003 core.
module mp3_cmd_ctrl #(
  parameter int unsigned NUM_SONGS      = 4,
  parameter int unsigned SONG_W         = 2,
  parameter logic [7:0]  VOL_INIT       = 8'h40,
  parameter logic [7:0]  VOL_STEP       = 8'h10,
  parameter logic [7:0]  VOL_MAX        = 8'hFE,
  parameter int unsigned HOLDOFF_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  input  logic [7:0]        i_cmd_byte,
  input  logic              i_finish,
  output logic [15:0]       o_vol,
  output logic              o_vol_update,
  output logic [SONG_W-1:0] o_song_idx,
  output logic              o_song_change,
  output logic              o_pause,
  output logic [1:0]        o_mode,
  output logic              o_busy
);

  localparam logic [SONG_W-1:0] LastIdx  = SONG_W'(NUM_SONGS - 1);
  localparam logic [15:0]       HoldLast = 16'(HOLDOFF_CYCLES - 1);

  typedef enum logic {StIdle, StHold} state_e;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [7:0]          left_q, left_d, right_q, right_d;
  logic [SONG_W-1:0]   idx_q, idx_d;
  logic                pause_q, pause_d;
  logic [1:0]          mode_q, mode_d;
  logic                vol_update_q, vol_update_d;
  logic                song_change_q, song_change_d;
  logic                song_ok;
  logic [7:0]          digit;
  logic [SONG_W-1:0]   idx_next, idx_prev, cand;

  function automatic logic [7:0] sat_dec(logic [7:0] x);
    return (x < VOL_STEP) ? 8'h00 : x - VOL_STEP;
  endfunction

  function automatic logic [7:0] sat_inc(logic [7:0] x);
    logic [8:0] sum;
    sum = {1'b0, x} + {1'b0, VOL_STEP};
    return (sum > {1'b0, VOL_MAX}) ? VOL_MAX : sum[7:0];
  endfunction

  assign song_ok  = (state_q == StIdle);
  assign digit    = i_cmd_byte - 8'h30;
  assign idx_next = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
  assign idx_prev = (idx_q == '0) ? LastIdx : idx_q - 1'b1;
  assign cand     = lfsr_q[SONG_W-1:0];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    left_d        = left_q;
    right_d       = right_q;
    idx_d         = idx_q;
    pause_d       = pause_q;
    mode_d        = mode_q;
    song_change_d = 1'b0;
    lfsr_d        = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    if (i_cmd_valid) begin
      case (i_cmd_byte)
        8'h2B: begin left_d = sat_dec(left_q); right_d = sat_dec(right_q); end
        8'h2D: begin left_d = sat_inc(left_q); right_d = sat_inc(right_q); end
        8'h4C: begin left_d = sat_dec(left_q); right_d = sat_inc(right_q); end
        8'h52: begin left_d = sat_inc(left_q); right_d = sat_dec(right_q); end
        8'h20: pause_d = ~pause_q;
        8'h4D: mode_d = mode_q + 2'd1;
        8'h4E: if (song_ok && !i_finish) begin
          idx_d = idx_next;
          song_change_d = 1'b1;
        end
        8'h50: if (song_ok && !i_finish) begin
          idx_d = idx_prev;
          song_change_d = 1'b1;
        end
        default: begin
          if (i_cmd_byte >= 8'h30 && i_cmd_byte <= 8'h39 && 32'(digit) < NUM_SONGS &&
              song_ok && !i_finish) begin
            idx_d = SONG_W'(digit);
            song_change_d = 1'b1;
          end
        end
      endcase
    end

    // Finish acts on the mode in force before any same-cycle 'M', and its pause effect wins.
    if (i_finish && song_ok) begin
      unique case (mode_q)
        2'd0: begin idx_d = idx_next; song_change_d = 1'b1; end
        2'd1: song_change_d = 1'b1;
        2'd2: begin
          idx_d = (32'(cand) >= NUM_SONGS || cand == idx_q) ? idx_next : cand;
          song_change_d = 1'b1;
        end
        2'd3: begin
          if (idx_q == LastIdx) begin
            pause_d = 1'b1;
          end else begin
            idx_d = idx_next;
            song_change_d = 1'b1;
          end
        end
      endcase
    end

    if (song_change_d) begin
      pause_d = 1'b0;
      state_d = StHold;
      cnt_d   = HoldLast;
    end else if (state_q == StHold) begin
      if (cnt_q == 16'd0) begin
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end

    vol_update_d = ({left_d, right_d} != {left_q, right_q});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= 16'd0;
      lfsr_q        <= 8'hA5;
      left_q        <= VOL_INIT;
      right_q       <= VOL_INIT;
      idx_q         <= '0;
      pause_q       <= 1'b0;
      mode_q        <= 2'd0;
      vol_update_q  <= 1'b0;
      song_change_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      left_q        <= left_d;
      right_q       <= right_d;
      idx_q         <= idx_d;
      pause_q       <= pause_d;
      mode_q        <= mode_d;
      vol_update_q  <= vol_update_d;
      song_change_q <= song_change_d;
    end
  end

  assign o_vol         = {left_q, right_q};
  assign o_vol_update  = vol_update_q;
  assign o_song_idx    = idx_q;
  assign o_song_change = song_change_q;
  assign o_pause       = pause_q;
  assign o_mode        = mode_q;
  assign o_busy        = (state_q == StHold);

endmodule

// File: tb/tb_mp3_cmd_ctrl.sv
// Randomized and directed bench for mp3_cmd_ctrl against a cycle-level behavioural model.
module tb_mp3_cmd_ctrl;

  localparam int NS    = 4;
  localparam int SW    = 2;
  localparam int HOLD  = 16;
  localparam int STEP  = 16;
  localparam int VMAX  = 254;
  localparam int VINIT = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [7:0]    cmd_byte = 8'h00;
  logic          finish = 1'b0;
  logic [15:0]   vol;
  logic          vol_update;
  logic [SW-1:0] song_idx;
  logic          song_change;
  logic          pause;
  logic [1:0]    mode;
  logic          busy;

  mp3_cmd_ctrl #(
    .NUM_SONGS      (NS),
    .SONG_W         (SW),
    .VOL_INIT       (8'h40),
    .VOL_STEP       (8'h10),
    .VOL_MAX        (8'hFE),
    .HOLDOFF_CYCLES (HOLD)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_valid   (cmd_valid),
    .i_cmd_byte    (cmd_byte),
    .i_finish      (finish),
    .o_vol         (vol),
    .o_vol_update  (vol_update),
    .o_song_idx    (song_idx),
    .o_song_change (song_change),
    .o_pause       (pause),
    .o_mode        (mode),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: attenuations, index, pause, mode, remaining busy cycles, pulses, LFSR.
  int         m_l, m_r, m_idx, m_pause, m_mode, m_rem;
  bit         m_vupd, m_chg;
  logic [7:0] m_lfsr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int vdec(int x);
    return (x < STEP) ? 0 : x - STEP;
  endfunction

  function automatic int vinc(int x);
    return (x + STEP > VMAX) ? VMAX : x + STEP;
  endfunction

  task automatic model(input bit rst, input bit v, input logic [7:0] b, input bit f);
    bit ok;
    int mode0, old_vol, cand;
    if (rst) begin
      m_l = VINIT; m_r = VINIT; m_idx = 0; m_pause = 0; m_mode = 0; m_rem = 0;
      m_vupd = 0; m_chg = 0; m_lfsr = 8'hA5;
      return;
    end
    ok      = (m_rem == 0);
    mode0   = m_mode;
    old_vol = m_l * 256 + m_r;
    m_chg   = 0;
    if (v) begin
      case (b)
        8'h2B: begin m_l = vdec(m_l); m_r = vdec(m_r); end
        8'h2D: begin m_l = vinc(m_l); m_r = vinc(m_r); end
        8'h4C: begin m_l = vdec(m_l); m_r = vinc(m_r); end
        8'h52: begin m_l = vinc(m_l); m_r = vdec(m_r); end
        8'h20: m_pause = 1 - m_pause;
        8'h4D: m_mode = (m_mode + 1) % 4;
        8'h4E: if (ok && !f) begin m_idx = (m_idx + 1) % NS; m_chg = 1; end
        8'h50: if (ok && !f) begin m_idx = (m_idx + NS - 1) % NS; m_chg = 1; end
        default: begin
          if (int'(b) >= 48 && int'(b) <= 57 && int'(b) - 48 < NS && ok && !f) begin
            m_idx = int'(b) - 48;
            m_chg = 1;
          end
        end
      endcase
    end
    if (f && ok) begin
      case (mode0)
        0: begin m_idx = (m_idx + 1) % NS; m_chg = 1; end
        1: m_chg = 1;
        2: begin
          cand  = int'(m_lfsr) % (1 << SW);
          m_idx = (cand >= NS || cand == m_idx) ? (m_idx + 1) % NS : cand;
          m_chg = 1;
        end
        default: begin
          if (m_idx == NS - 1) m_pause = 1;
          else begin m_idx = m_idx + 1; m_chg = 1; end
        end
      endcase
    end
    if (m_chg) begin
      m_pause = 0;
      m_rem   = HOLD;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    m_vupd = (m_l * 256 + m_r) != old_vol;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  task automatic apply(input bit rst, input bit v, input logic [7:0] b, input bit f);
    @(negedge clk);
    rst_n = !rst; cmd_valid = v; cmd_byte = b; finish = f;
    @(posedge clk);
    model(rst, v, b, f);
    #1;
    check("vol",         32'(vol),         32'(m_l * 256 + m_r));
    check("vol_update",  32'(vol_update),  32'(m_vupd));
    check("song_idx",    32'(song_idx),    32'(m_idx));
    check("song_change", 32'(song_change), 32'(m_chg));
    check("pause",       32'(pause),       32'(m_pause));
    check("mode",        32'(mode),        32'(m_mode));
    check("busy",        32'(busy),        32'(m_rem > 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 8'h00, 0);
  endtask

  task automatic do_reset();
    apply(1, 0, 8'h00, 0);
    apply(1, 0, 8'h00, 0);
  endtask

  logic [15:0] plus_vol [5];
  logic        plus_upd [5];
  int          busy_cnt, prev_idx;
  logic [7:0]  tbl [14];
  logic [7:0]  b;

  initial begin
    plus_vol = '{16'h3030, 16'h2020, 16'h1010, 16'h0000, 16'h0000};
    plus_upd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl = '{8'h2B, 8'h2D, 8'h4C, 8'h52, 8'h4E, 8'h50, 8'h20, 8'h4D,
            8'h30, 8'h31, 8'h32, 8'h33, 8'h37, 8'h41};

    do_reset();
    check("reset_vol", 32'(vol), 32'h4040);
    check("reset_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 8'h2B, 0);
      check("plus_vol", 32'(vol), 32'(plus_vol[i]));
      check("plus_upd", 32'(vol_update), 32'(plus_upd[i]));
    end

    do_reset();
    apply(0, 1, 8'h4C, 0);
    check("balance_l", 32'(vol), 32'h3050);
    for (int i = 0; i < 15; i++) apply(0, 1, 8'h2D, 0);
    check("minus_sat", 32'(vol), 32'hFEFE);
    check("minus_sat_upd", 32'(vol_update), 32'h0);

    do_reset();
    apply(0, 1, 8'h50, 0);
    check("prev_wrap", 32'(song_idx), 32'd3);
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) apply(0, 1, 8'h4E, 0);
      else        apply(0, 0, 8'h00, 0);
      if (busy) busy_cnt++;
    end
    check("holdoff_len", 32'(busy_cnt), 32'd16);
    check("holdoff_drop", 32'(song_idx), 32'd3);
    apply(0, 1, 8'h4E, 0);
    check("next_wrap", 32'(song_idx), 32'd0);

    do_reset();
    for (int i = 0; i < 3; i++) apply(0, 1, 8'h4D, 0);
    apply(0, 1, 8'h33, 0);
    idle(HOLD);
    apply(0, 0, 8'h00, 1);
    check("stop_end_idx", 32'(song_idx), 32'd3);
    check("stop_end_pause", 32'(pause), 32'd1);
    check("stop_end_chg", 32'(song_change), 32'd0);

    do_reset();
    apply(0, 1, 8'h33, 0);
    idle(HOLD);
    apply(0, 0, 8'h00, 1);
    check("seq_wrap", 32'(song_idx), 32'd0);

    do_reset();
    apply(0, 1, 8'h4D, 0);
    apply(0, 1, 8'h4D, 0);
    for (int i = 0; i < 50; i++) begin
      prev_idx = m_idx;
      apply(0, 0, 8'h00, 1);
      check("shuffle_diff", 32'(song_idx != SW'(prev_idx)), 32'd1);
      check("shuffle_range", 32'(int'(song_idx) < NS), 32'd1);
      idle(HOLD + 2);
    end

    do_reset();
    apply(0, 1, 8'h37, 1);
    check("finish_wins", 32'(song_idx), 32'd1);
    idle(HOLD);
    apply(0, 1, 8'h37, 0);
    check("digit_range", 32'(song_idx), 32'd1);
    apply(0, 1, 8'h20, 0);
    check("pause_on", 32'(pause), 32'd1);
    apply(0, 1, 8'h32, 0);
    check("pause_clr", 32'(pause), 32'd0);
    check("digit_sel", 32'(song_idx), 32'd2);

    for (int i = 0; i < 3000; i++) begin
      b = ($urandom_range(7) == 0) ? 8'($urandom) : tbl[$urandom_range(13)];
      apply($urandom_range(399) == 0, $urandom_range(1) == 1, b, $urandom_range(15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
